ptos_rr_sched: RTL and testbench
================================

Name: ptos_rr_sched

Overview:
- Round-robin scheduler that shares one 4-bit parallel-to-serial (scl/sda) serializer between NUM_REQ requesters.
- Grants one requester at a time and drives that requester's nibble onto the serializer data input.
- Tracks the serializer's ack handshake (rise = ready to load, fall = nibble latched and shifting), then enforces a guard interval so the frame finishes before the next grant.
- Sits between client logic and the serializer, in the same sclk domain.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- GAP_CYC, 12, sclk cycles after ack fall before the frame is considered complete (≥1)
- PTR_W, 2, width of round-robin pointer, = clog2(NUM_REQ)

Ports:
- sclk  input  1  system clock, all state on posedge
- rst  input  1  asynchronous active-low reset
- req  input  NUM_REQ  per-requester transfer request, level
- req_data  input  4*NUM_REQ  nibble of requester i at [4i+3:4i]
- gnt  output  NUM_REQ  one-hot grant, held for the whole transaction
- done  output  NUM_REQ  one-cycle pulse on the granted bit at transaction end
- ser_data  output  4  nibble to serializer data input
- ser_ack  input  1  serializer ack (changes on negedge sclk)
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (rst=0, async): state=IDLE, gnt=0, done=0, ser_data=4'h0, busy=0, ptr=0, gap counter=0.
- FSM states: IDLE, GRANT, LATCH, GUARD.
- IDLE, req!=0:
  - winner = first set req bit searching ptr, ptr+1, … modulo NUM_REQ.
  - Next edge: gnt=onehot(winner), ser_data=req_data[winner], state→GRANT.
  - req=0: stay; outputs unchanged except done=0.
- GRANT: ser_ack=1 sampled → LATCH; otherwise hold.
- LATCH: ser_ack=0 sampled → GUARD; gap counter loads GAP_CYC-1.
- GUARD:
  - Counter decrements each edge.
  - Edge where counter==0: done[winner]=1 for exactly one cycle, gnt=0, ptr=(winner+1) mod NUM_REQ, state→IDLE.
- No back-to-back grant: at least one IDLE cycle separates transactions.
  - Earliest re-grant is the edge after the done pulse.
- ser_data is captured at grant and held constant through GUARD.
  - Later changes on req_data are ignored. ser_data retains its last value in IDLE.
- A requester dropping req after grant does not abort; the transaction completes and done is still pulsed.
- Latency: req rise (from idle) → gnt on the next posedge. Minimum transaction = 3 + GAP_CYC cycles plus the serializer ack delay.
- ser_ack already high when GRANT is entered → LATCH on the first GRANT edge.
- Pointer wrap: winner NUM_REQ-1 → ptr=0.
- All req bits set continuously → grants rotate 0,1,2,…,NUM_REQ-1,0.
- Reset mid-transaction: everything returns to reset values immediately; no done pulse is issued.

Optional Feature:
- Macro: PTOS_RR_SCHED_TIMEOUT_EN.
- Defined:
  - Adds parameter TMO_CYC (default 64) and output err (1 bit, reset 0).
  - If GRANT or LATCH persists TMO_CYC cycles, err pulses for 1 cycle and done is not pulsed.
  - gnt clears, ptr advances past the winner, state→IDLE.
- Undefined: no err port, no timeout; GRANT/LATCH wait indefinitely.

Decomposition:
- Shared package ptos_pkg:
  - state encoding constants (IDLE=2'd0, GRANT=2'd1, LATCH=2'd2, GUARD=2'd3)
  - nibble width constant NIB_W=4
  - default GAP_CYC
- One sub-module, ptos_rr_pick: combinational round-robin picker.
  - Inputs: req, ptr.
  - Outputs: winner index, any_req.
  - Instantiated once.

Test Plan:
- Reset then req=4'b0100, req_data[11:8]=4'hA → gnt=4'b0100 one edge later, ser_data=4'hA. Drive ser_ack high 3 cycles, then low → done[2] pulses GAP_CYC (12) edges after ack-low sample; ptr=3.
- req=4'b1111 held, ser_ack model auto-responds → grant order 0,1,2,3,0. Each done single-cycle, busy low exactly 1 cycle between transactions.
- After grant to 1 with req_data[7:4]=4'h5, change req_data to 4'hF and drop req[1] → ser_data stays 4'h5, done[1] still pulses.
- Assert rst=0 during GUARD → gnt=0, busy=0, done=0 immediately. After release, req=4'b0010 → grant to 1 (ptr reset to 0).
- req=4'b1001 with ptr=1 → grant 3 first, then 0.
- With PTOS_RR_SCHED_TIMEOUT_EN, TMO_CYC=64, ser_ack held 0 → err pulses at cycle 64 of GRANT, no done, gnt clears, next grant goes to the next requester.

Source files
------------

// File: rtl/ptos_pkg.sv
// Shared definitions for the round-robin serializer scheduler: state encoding,
// nibble width and the default guard interval.
package ptos_pkg;

    localparam int NIB_W       = 4;
    localparam int GAP_CYC_DEF = 12;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_LATCH = 2'd2,
        ST_GUARD = 2'd3
    } state_e;

endpackage

// File: rtl/ptos_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
// Zero latency; no flow control.
module ptos_rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [PTR_W-1:0]   winner,
    output logic               any_req
);

    int idx;

    // Scan from the farthest offset down so the nearest hit to ptr wins.
    always_comb begin
        winner  = '0;
        any_req = 1'b0;
        idx     = 0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (req[idx]) begin
                winner  = PTR_W'(idx);
                any_req = 1'b1;
            end
        end
    end

endmodule

// File: rtl/ptos_rr_sched.sv
// Round-robin owner of one 4-bit serializer: grant on the edge after req, hold through
// ack rise/fall plus GAP_CYC guard, then pulse done. PTOS_RR_SCHED_TIMEOUT_EN adds err/TMO_CYC.
module ptos_rr_sched
    import ptos_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int GAP_CYC = GAP_CYC_DEF,
    parameter int PTR_W   = $clog2(NUM_REQ)
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
    ,
    parameter int TMO_CYC = 64
`endif
) (
    input  logic                     sclk,
    input  logic                     rst,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NIB_W*NUM_REQ-1:0] req_data,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic [NIB_W-1:0]         ser_data,
    input  logic                     ser_ack,
    output logic                     busy
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
    ,
    output logic                     err
`endif
);

    localparam int CNT_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;

    state_e             state_q, state_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;
    logic [NIB_W-1:0]   ser_data_q, ser_data_d;
    logic [PTR_W-1:0]   ptr_q, ptr_d;
    logic [PTR_W-1:0]   win_q, win_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [PTR_W-1:0]   pick_win;
    logic               pick_any;
    logic [PTR_W-1:0]   next_ptr;

`ifdef PTOS_RR_SCHED_TIMEOUT_EN
    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             err_q, err_d;
`endif

    ptos_rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req     (req),
        .ptr     (ptr_q),
        .winner  (pick_win),
        .any_req (pick_any)
    );

    assign next_ptr = (win_q == PTR_W'(NUM_REQ - 1)) ? '0 : win_q + PTR_W'(1);

    always_comb begin
        state_d    = state_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        ser_data_d = ser_data_q;
        ptr_d      = ptr_q;
        win_d      = win_q;
        cnt_d      = cnt_q;
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
        tmo_d      = tmo_q;
        err_d      = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    gnt_d      = NUM_REQ'(1) << pick_win;
                    ser_data_d = req_data[NIB_W*int'(pick_win) +: NIB_W];
                    win_d      = pick_win;
                    state_d    = ST_GRANT;
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
                    tmo_d      = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (ser_ack) state_d = ST_LATCH;
            end
            ST_LATCH: begin
                if (!ser_ack) begin
                    state_d = ST_GUARD;
                    cnt_d   = CNT_W'(GAP_CYC - 1);
                end
            end
            ST_GUARD: begin
                if (cnt_q == '0) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    ptr_d   = next_ptr;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
        // A stalled handshake abandons the grant; the serializer never latched it.
        if (state_q == ST_GRANT || state_q == ST_LATCH) begin
            if (tmo_q == TMO_W'(TMO_CYC - 1)) begin
                err_d   = 1'b1;
                gnt_d   = '0;
                ptr_d   = next_ptr;
                state_d = ST_IDLE;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge sclk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            gnt_q      <= '0;
            done_q     <= '0;
            ser_data_q <= '0;
            ptr_q      <= '0;
            win_q      <= '0;
            cnt_q      <= '0;
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
            tmo_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            ser_data_q <= ser_data_d;
            ptr_q      <= ptr_d;
            win_q      <= win_d;
            cnt_q      <= cnt_d;
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
            tmo_q      <= tmo_d;
            err_q      <= err_d;
`endif
        end
    end

    assign gnt      = gnt_q;
    assign done     = done_q;
    assign ser_data = ser_data_q;
    assign busy     = (state_q != ST_IDLE);
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
    assign err      = err_q;
`endif

endmodule

// File: tb/tb_ptos_rr_sched.sv
// Randomized bench for ptos_rr_sched with a transaction-level reference model
// and a handful of hand-computed directed expectations.
module tb_ptos_rr_sched;

    localparam int N   = 4;
    localparam int GAP = 12;

    logic          sclk = 1'b0;
    logic          rst  = 1'b1;
    logic [N-1:0]  req  = '0;
    logic [4*N-1:0] req_data = '0;
    logic          ser_ack = 1'b0;
    logic [N-1:0]  gnt;
    logic [N-1:0]  done;
    logic [3:0]    ser_data;
    logic          busy;
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
    logic          err;
`endif

    always #5 sclk = ~sclk;

    ptos_rr_sched #(
        .NUM_REQ (N),
        .GAP_CYC (GAP),
        .PTR_W   (2)
    ) dut (
`ifdef PTOS_RR_SCHED_TIMEOUT_EN
        .err      (err),
`endif
        .sclk     (sclk),
        .rst      (rst),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .done     (done),
        .ser_data (ser_data),
        .ser_ack  (ser_ack),
        .busy     (busy)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: a transaction is "waiting for ack rise", "waiting for
    // ack fall", then a countdown of GAP edges ending in done.
    int         m_phase;
    int         m_win;
    int         m_ptr;
    int         m_left;
    logic [N-1:0] m_gnt;
    logic [N-1:0] m_done;
    logic [3:0]   m_ser;

    function automatic int rr_pick(input logic [N-1:0] r, input int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic m_reset();
        m_phase = 0; m_win = 0; m_ptr = 0; m_left = 0;
        m_gnt = '0; m_done = '0; m_ser = '0;
    endtask

    task automatic m_step();
        m_done = '0;
        case (m_phase)
            0: begin
                if (req != '0) begin
                    m_win   = rr_pick(req, m_ptr);
                    m_gnt   = '0;
                    m_gnt[m_win] = 1'b1;
                    m_ser   = req_data[4*m_win +: 4];
                    m_phase = 1;
                end
            end
            1: if (ser_ack) m_phase = 2;
            2: if (!ser_ack) begin m_phase = 3; m_left = GAP; end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_done = m_gnt;
                    m_gnt  = '0;
                    m_ptr  = (m_win + 1) % N;
                    m_phase = 0;
                end
            end
        endcase
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge sclk or negedge rst);
            if (!rst) m_reset();
            else m_step();
        end
    end

    bit cmp_on = 1'b0;
    initial begin
        forever begin
            @(negedge sclk);
            if (cmp_on) begin
                chk("gnt", 32'(gnt), 32'(m_gnt));
                chk("done", 32'(done), 32'(m_done));
                chk("ser_data", 32'(ser_data), 32'(m_ser));
                chk("busy", 32'(busy), 32'(m_phase != 0));
            end
        end
    end

    // Grant order and idle-gap lengths observed on the DUT.
    int   gq[$];
    int   gapq[$];
    int   idle_run = 0;
    logic [N-1:0] prev_gnt = '0;
    initial begin
        forever begin
            @(negedge sclk);
            if (gnt != '0 && prev_gnt == '0)
                for (int k = 0; k < N; k++) if (gnt[k]) gq.push_back(k);
            prev_gnt = gnt;
            if (!busy) idle_run++;
            else if (idle_run > 0) begin gapq.push_back(idle_run); idle_run = 0; end
        end
    end

    // Serializer stand-in: raises ack after a random delay (sometimes already
    // high before the grant), holds it a few cycles, then drops it.
    bit auto_en = 1'b0;
    int a_st = 0, a_dly = 0, a_hold = 0;
    initial begin
        forever begin
            @(posedge sclk); #3;
            if (!rst) begin
                a_st = 0; ser_ack = 1'b0;
            end else if (auto_en) begin
                case (a_st)
                    0: if (gnt != '0) begin
                        if (ser_ack) begin a_hold = $urandom_range(1, 3); a_st = 2; end
                        else begin a_dly = $urandom_range(0, 3); a_st = 1; end
                    end
                    1: if (a_dly == 0) begin ser_ack = 1'b1; a_hold = $urandom_range(1, 3); a_st = 2; end
                       else a_dly--;
                    2: if (a_hold <= 1) begin ser_ack = 1'b0; a_st = 3; end
                       else a_hold--;
                    default: if (gnt == '0) begin
                        if ($urandom_range(0, 3) == 0) ser_ack = 1'b1;
                        a_st = 0;
                    end
                endcase
            end
        end
    end

    task automatic tick();
        @(posedge sclk); #2;
    endtask

    task automatic wait_grants(input int n, input string nm);
        int c = 0;
        while (gq.size() < n && c < 600) begin @(negedge sclk); c++; end
        if (gq.size() < n) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: timeout with %0d grants, required %0d", nm, gq.size(), n);
        end
    endtask

    task automatic wait_idle(input string nm);
        int c = 0;
        @(negedge sclk);
        while (busy && c < 600) begin @(negedge sclk); c++; end
        if (busy) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: busy still 1 after timeout, required 0", nm);
        end
    endtask

    task automatic wait_done(input string nm, output logic [N-1:0] d);
        int c = 0;
        d = '0;
        while (c < 600) begin
            @(negedge sclk); c++;
            if (done != '0) begin d = done; break; end
        end
        if (d == '0) begin
            n_cmp++; n_fail++;
            $display("FAIL %s: no done pulse before timeout", nm);
        end
    endtask

    initial begin
        logic [N-1:0] d;
        int n;
        int c;

        #1 rst = 1'b0;
        repeat (3) @(posedge sclk);
        @(negedge sclk);
        chk("rst_gnt", 32'(gnt), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_ser", 32'(ser_data), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        cmp_on = 1'b1;
        tick(); rst = 1'b1;
        req_data = 16'h4321;

        // Everyone requesting: strict rotation starting from ptr 0.
        auto_en = 1'b1;
        tick(); gq.delete(); gapq.delete(); req = 4'hF;
        wait_grants(5, "rot_wait");
        tick(); req = '0;
        wait_idle("rot_idle");
        if (gq.size() >= 5) begin
            chk("rot0", 32'(gq[0]), 32'd0);
            chk("rot1", 32'(gq[1]), 32'd1);
            chk("rot2", 32'(gq[2]), 32'd2);
            chk("rot3", 32'(gq[3]), 32'd3);
            chk("rot4", 32'(gq[4]), 32'd0);
        end
        if (gapq.size() >= 5)
            for (int k = 1; k < 5; k++) chk("rot_gap", 32'(gapq[k]), 32'd1);

        // ptr is now 1: 1001 must go to 3 first, then wrap to 0.
        tick(); gq.delete(); req = 4'b1001;
        wait_grants(2, "wrap_wait");
        tick(); req = '0;
        wait_idle("wrap_idle");
        if (gq.size() >= 2) begin
            chk("wrap0", 32'(gq[0]), 32'd3);
            chk("wrap1", 32'(gq[1]), 32'd0);
        end

        // Hand-driven handshake, counting guard edges to done.
        auto_en = 1'b0; ser_ack = 1'b0;
        tick(); req = 4'b0100; req_data[11:8] = 4'hA;
        @(posedge sclk); @(negedge sclk);
        chk("t1_gnt", 32'(gnt), 32'h4);
        chk("t1_ser", 32'(ser_data), 32'hA);
        tick(); req = '0; ser_ack = 1'b1;
        tick(); tick(); tick(); ser_ack = 1'b0;
        @(posedge sclk);
        n = 0;
        for (c = 0; c < 40; c++) begin
            @(posedge sclk); n++;
            @(negedge sclk);
            if (done != '0) break;
        end
        chk("t1_gap_edges", 32'(n), 32'd12);
        chk("t1_done", 32'(done), 32'h4);
        @(negedge sclk);
        chk("t1_done_1cyc", 32'(done), 32'h0);
        auto_en = 1'b1;
        tick(); gq.delete(); req = 4'b1001;
        wait_grants(1, "t1_ptr_wait");
        tick(); req = '0;
        if (gq.size() >= 1) chk("t1_ptr3", 32'(gq[0]), 32'd3);
        wait_idle("t1_idle");

        // Data and req change after grant are ignored; done still fires.
        tick(); gq.delete(); req = 4'b0010; req_data[7:4] = 4'h5;
        wait_grants(1, "t3_wait");
        tick(); req_data[7:4] = 4'hF; req = '0;
        wait_done("t3_done_wait", d);
        chk("t3_done", 32'(d), 32'h2);
        chk("t3_ser", 32'(ser_data), 32'h5);
        wait_idle("t3_idle");

        // Reset in the guard interval, then ptr must be back at 0.
        tick(); req = 4'b0100;
        c = 0;
        while (m_phase != 3 && c < 200) begin tick(); c++; end
        chk("t4_reached_guard", 32'(m_phase), 32'd3);
        tick(); tick(); req = '0; rst = 1'b0;
        #1;
        chk("t4_gnt", 32'(gnt), 32'h0);
        chk("t4_busy", 32'(busy), 32'h0);
        chk("t4_done", 32'(done), 32'h0);
        tick(); tick(); rst = 1'b1;
        tick(); gq.delete(); req = 4'b0110;
        wait_grants(1, "t4_wait");
        tick(); req = '0;
        if (gq.size() >= 1) chk("t4_ptr0", 32'(gq[0]), 32'd1);
        wait_idle("t4_idle");

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick();
            if ($urandom_range(0, 7) == 0) req = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 0) req_data = 16'($urandom);
        end
        tick(); req = '0;
        wait_idle("rand_idle");
        repeat (2) @(negedge sclk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
